// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_channel_decoder
// Description : TMDS receive channel. Finds symbol alignment by bit-slip
//               search on control-token runs, then decodes the symbols.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS = 16,
    parameter int DWELL       = 1024,
    parameter int TIMEOUT     = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_word,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RUN_W   = (LOCK_TOKENS > 1) ? $clog2(LOCK_TOKENS) : 1;
    localparam int DWELL_W = (DWELL > 1)       ? $clog2(DWELL)       : 1;
    localparam int TO_W    = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;

    localparam logic [RUN_W-1:0]   c_run_max   = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [DWELL_W-1:0] c_dwell_max = DWELL_W'(DWELL - 1);
    localparam logic [TO_W-1:0]    c_to_max    = TO_W'(TIMEOUT - 1);

    localparam logic [0:0] c_st_search = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [9:0]         r_prev;
    logic [9:0]         r_sym;
    logic [19:0]        w_window;
    logic [9:0]         w_sym;
    logic               w_is_tok;
    logic [1:0]         w_tok_ctrl;
    logic [7:0]         w_d;
    logic [7:0]         w_data;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [RUN_W-1:0]   r_run;
    logic [DWELL_W-1:0] r_dwell;
    logic [TO_W-1:0]    r_timeout;
    logic [3:0]         r_offset;
    logic [3:0]         w_offset_nxt;
    logic               w_lock_hit;
    logic               r_de;
    logic [1:0]         r_ctrl;
    logic [7:0]         r_data;

    // Stage 1 holds the previous word; stage 2 holds the aligned symbol.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_prev <= 10'd0;
            r_sym  <= 10'd0;
        end else begin
            r_prev <= tmds_word;
            r_sym  <= w_sym;
        end
    end

    assign w_window = {tmds_word, r_prev};

    always_comb begin
        w_sym = w_window[9:0];
        case (r_offset)
            4'd1:    w_sym = w_window[10:1];
            4'd2:    w_sym = w_window[11:2];
            4'd3:    w_sym = w_window[12:3];
            4'd4:    w_sym = w_window[13:4];
            4'd5:    w_sym = w_window[14:5];
            4'd6:    w_sym = w_window[15:6];
            4'd7:    w_sym = w_window[16:7];
            4'd8:    w_sym = w_window[17:8];
            4'd9:    w_sym = w_window[18:9];
            default: w_sym = w_window[9:0];
        endcase
    end

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_ctrl = 2'b00;
        case (r_sym)
            10'h354: w_tok_ctrl = 2'b00;
            10'h0AB: w_tok_ctrl = 2'b01;
            10'h154: w_tok_ctrl = 2'b10;
            10'h2AB: w_tok_ctrl = 2'b11;
            default: w_is_tok   = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        w_d       = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_data    = 8'd0;
        w_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    assign w_lock_hit   = w_is_tok && (r_run == c_run_max);
    assign w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state <= c_st_search;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_search: begin
                if (w_lock_hit) begin
                    w_state_nxt = c_st_locked;
                end
            end
            c_st_locked: begin
                if (!w_is_tok && (r_timeout == c_to_max)) begin
                    w_state_nxt = c_st_search;
                end
            end
            default: w_state_nxt = c_st_search;
        endcase
    end

    always_comb begin
        locked = (r_state == c_st_locked);
    end

    // Lock takes priority over dwell expiry, so the offset stays put.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_run     <= '0;
            r_dwell   <= '0;
            r_timeout <= '0;
            r_offset  <= 4'd0;
        end else if (r_state == c_st_search) begin
            if (w_lock_hit) begin
                r_run     <= '0;
                r_dwell   <= '0;
                r_timeout <= '0;
            end else if (r_dwell == c_dwell_max) begin
                r_run    <= '0;
                r_dwell  <= '0;
                r_offset <= w_offset_nxt;
            end else begin
                r_run   <= w_is_tok ? r_run + 1'b1 : '0;
                r_dwell <= r_dwell + 1'b1;
            end
        end else begin
            if (w_is_tok) begin
                r_timeout <= '0;
            end else if (r_timeout == c_to_max) begin
                r_timeout <= '0;
                r_run     <= '0;
                r_dwell   <= '0;
                r_offset  <= w_offset_nxt;
            end else begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    // Gating on the next state keeps outputs in step with the locked flag.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
            r_data <= 8'd0;
        end else if (w_state_nxt == c_st_locked) begin
            r_de   <= !w_is_tok;
            r_ctrl <= w_is_tok ? w_tok_ctrl : 2'b00;
            r_data <= w_is_tok ? 8'd0 : w_data;
        end else begin
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
            r_data <= 8'd0;
        end
    end

    assign de     = r_de;
    assign ctrl   = r_ctrl;
    assign data   = r_data;
    assign offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_channel_decoder
// Description : Directed vector bench for the TMDS channel decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

    localparam int LT = 16;
    localparam int DW = 64;
    localparam int TO = 256;
    localparam int NV = 260;

    typedef struct {
        logic [9:0] word;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } vec_t;

    logic       pixel_clk = 1'b0;
    logic       rst;
    logic [9:0] tmds_word;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] offset;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];

    tmds_channel_decoder #(
        .LOCK_TOKENS(LT),
        .DWELL      (DW),
        .TIMEOUT    (TO)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .tmds_word(tmds_word),
        .de       (de),
        .ctrl     (ctrl),
        .data     (data),
        .locked   (locked),
        .offset   (offset)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference transmitter with running disparity.
    task automatic tmds_encode(input logic [7:0] d, inout int cnt, output logic [9:0] q);
        logic [8:0] qm;
        int n1d;
        int n1q;
        int n0q;
        n1d   = $countones(d);
        qm    = 9'd0;
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8] == 1'b0) cnt = cnt + n0q - n1q;
            else               cnt = cnt + n1q - n0q;
        end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
            q   = {1'b1, qm[8], ~qm[7:0]};
            cnt = cnt + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q   = {1'b0, qm[8], qm[7:0]};
            cnt = cnt - (qm[8] ? 0 : 2) + n1q - n0q;
        end
    endtask

    task automatic do_reset(input logic [9:0] w);
        @(negedge pixel_clk);
        rst       = 1'b1;
        tmds_word = w;
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    // Drives w each cycle until locked equals want; cyc = max on expiry.
    task automatic run_until(input logic [9:0] w, input logic want, input int max, output int cyc);
        cyc = max;
        for (int c = 0; c < max; c++) begin
            @(negedge pixel_clk);
            if (locked === want) begin
                cyc = c;
                break;
            end
            tmds_word = w;
        end
    endtask

    initial begin
        int         cnt;
        int         cyc;
        int         lim;
        logic [9:0] q;
        logic [9:0] w;
        logic [19:0] pair;
        logic [9:0] toks[4];

        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        cnt  = 0;
        for (int b = 0; b < 128; b++) begin
            tmds_encode(8'(b), cnt, q);
            vecs[b] = '{word: q, de: 1'b1, ctrl: 2'd0, data: 8'(b)};
        end
        for (int t = 0; t < 4; t++) begin
            vecs[128 + t] = '{word: toks[t], de: 1'b0, ctrl: 2'(t), data: 8'd0};
        end
        cnt = 0;
        for (int b = 128; b < 256; b++) begin
            tmds_encode(8'(b), cnt, q);
            vecs[b + 4] = '{word: q, de: 1'b1, ctrl: 2'd0, data: 8'(b)};
        end

        rst       = 1'b1;
        tmds_word = 10'h000;

        do_reset(10'h354);
        check("reset_outputs", 32'({de, ctrl, data, locked, offset}), 32'd0);

        run_until(10'h354, 1'b1, LT + 3, cyc);
        check("lock_aligned_cycles", 32'(cyc), 32'd17);
        check("lock_aligned_offset", 32'(offset), 32'd0);
        check("lock_aligned_ctrl", 32'({de, ctrl}), 32'd0);

        repeat (64) begin
            @(negedge pixel_clk);
            tmds_word = 10'h354;
        end
        for (int i = 0; i < NV + 3; i++) begin
            @(negedge pixel_clk);
            if (i >= 3) begin
                check($sformatf("vec_de[%0d]", i - 3), 32'(de), 32'(vecs[i-3].de));
                if (vecs[i-3].de)
                    check($sformatf("vec_data[%0d]", i - 3), 32'(data), 32'(vecs[i-3].data));
                else
                    check($sformatf("vec_ctrl[%0d]", i - 3), 32'(ctrl), 32'(vecs[i-3].ctrl));
            end
            tmds_word = (i < NV) ? vecs[i].word : 10'h354;
        end
        check("vec_still_locked", 32'(locked), 32'd1);

        run_until(10'h000, 1'b0, TO + 40, cyc);
        check("timeout_cycles", 32'(cyc), 32'd258);
        check("timeout_offset", 32'(offset), 32'd1);
        check("timeout_outputs", 32'({de, ctrl, data}), 32'd0);

        lim = 10 * DW + LT + 8;
        run_until(10'h354, 1'b1, lim, cyc);
        check("relock_in_budget", 32'(cyc < lim), 32'd1);
        check("relock_offset", 32'(offset), 32'd0);

        for (int s = 0; s < 10; s++) begin
            pair = {10'h354, 10'h354};
            w    = pair[10 - s +: 10];
            do_reset(w);
            lim = (s + 1) * DW + LT + 3;
            run_until(w, 1'b1, lim, cyc);
            check($sformatf("shift_lock[%0d]", s), 32'(cyc < lim), 32'd1);
            check($sformatf("shift_offset[%0d]", s), 32'(offset), 32'(s));
        end

        repeat (5) begin
            @(negedge pixel_clk);
            tmds_word = 10'h000;
        end
        @(negedge pixel_clk);
        check("mid_data_de", 32'(de), 32'd1);
        check("mid_data_byte", 32'(data), 32'hFE);
        check("mid_data_locked", 32'({locked, offset}), 32'h19);
        rst       = 1'b1;
        tmds_word = 10'h354;
        @(negedge pixel_clk);
        check("mid_reset_outputs", 32'({de, ctrl, data, locked, offset}), 32'd0);
        rst = 1'b0;
        run_until(10'h354, 1'b1, LT + 3, cyc);
        check("relock_after_reset", 32'(cyc), 32'd17);
        check("relock_after_reset_offset", 32'(offset), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
